// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Hazard, forwarding and scoreboard controller for an in-order 5-stage
// pipeline. It sits beside the ID stage.
//
// Ports:
//   clk, rst_n                        clock and asynchronous active-low reset
//   id_rs, id_rt, id_uses_rs/rt       ID source registers and their read flags
//   id_long                           the ID instruction is a long op
//   ex_rd/mem_rd/wb_rd, *_reg_write   destinations and write enables downstream
//   ex_mem_read                       EX holds a load
//   ex_long_start                     EX issues a long op to ex_rd
//   ex_branch_taken                   EX resolved a taken branch or jump
//   perf_clr                          synchronous clear of stall_cnt
//   forward_a/b                       operand select: 11 EX, 01 MEM, 10 WB, 00 RF
//   stall, bubble_ex                  freeze PC and IF/ID, insert NOP into ID/EX
//   flush_if, flush_id                squash IF/ID and ID/EX
//   long_busy, long_done, long_rd     long-unit scoreboard status
//   stall_cnt                         saturating stall-cycle counter
module hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int IGNORE_REG0 = 1,
  parameter int LONG_LAT    = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_long,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             ex_reg_write,
  input  logic             mem_reg_write,
  input  logic             wb_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_long_start,
  input  logic             ex_branch_taken,
  input  logic             perf_clr,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             stall,
  output logic             bubble_ex,
  output logic             flush_if,
  output logic             flush_id,
  output logic             long_busy,
  output logic             long_done,
  output logic [REG_W-1:0] long_rd,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int LAT_W = $clog2(LONG_LAT + 1);

  logic [LAT_W-1:0] lat_cnt_r;
  logic [REG_W-1:0] long_rd_r;
  logic [CNT_W-1:0] stall_cnt_r;

  logic             long_busy_s;
  logic             stall_s;
  logic [1:0]       fwd_a_s;
  logic [1:0]       fwd_b_s;

  // Source-versus-destination match; register 0 optionally never matches.
  function automatic logic src_match_f(
    input logic [REG_W-1:0] addr,
    input logic             uses,
    input logic [REG_W-1:0] rd,
    input logic             en
  );
    logic zero_blk;
    zero_blk    = (IGNORE_REG0 != 0) && (addr == '0);
    src_match_f = uses && en && (addr == rd) && !zero_blk;
  endfunction

  // Forward select encoding with EX > MEM > WB priority.
  function automatic logic [1:0] fwd_sel_f(
    input logic hit_ex,
    input logic hit_mem,
    input logic hit_wb
  );
    if (hit_ex) begin
      fwd_sel_f = 2'b11;
    end else if (hit_mem) begin
      fwd_sel_f = 2'b01;
    end else if (hit_wb) begin
      fwd_sel_f = 2'b10;
    end else begin
      fwd_sel_f = 2'b00;
    end
  endfunction

  assign long_busy_s = (lat_cnt_r != '0);

  // Stall and forwarding decode; the long unit match ignores write enables.
  always_comb begin
    logic ex_a, ex_b, mem_a, mem_b, wb_a, wb_b, lg_a, lg_b;
    logic load_use, long_stall;
    ex_a  = src_match_f(id_rs, id_uses_rs, ex_rd,  ex_reg_write);
    ex_b  = src_match_f(id_rt, id_uses_rt, ex_rd,  ex_reg_write);
    mem_a = src_match_f(id_rs, id_uses_rs, mem_rd, mem_reg_write);
    mem_b = src_match_f(id_rt, id_uses_rt, mem_rd, mem_reg_write);
    wb_a  = src_match_f(id_rs, id_uses_rs, wb_rd,  wb_reg_write);
    wb_b  = src_match_f(id_rt, id_uses_rt, wb_rd,  wb_reg_write);
    lg_a  = src_match_f(id_rs, id_uses_rs, long_rd_r, long_busy_s);
    lg_b  = src_match_f(id_rt, id_uses_rt, long_rd_r, long_busy_s);

    load_use   = ex_mem_read && (ex_a || ex_b);
    // The long_done cycle still stalls: the result only lands that cycle.
    long_stall = long_busy_s && (lg_a || lg_b || id_long);
    // A taken branch discards the ID instruction, so it wins over stalling.
    stall_s    = (load_use || long_stall) && !ex_branch_taken;

    if (stall_s) begin
      fwd_a_s = 2'b00;
      fwd_b_s = 2'b00;
    end else begin
      fwd_a_s = fwd_sel_f(ex_a, mem_a, wb_a);
      fwd_b_s = fwd_sel_f(ex_b, mem_b, wb_b);
    end
  end

  // Long-unit scoreboard: load on issue when idle, count down to zero.
  // Issue while busy is ignored; the structural stall keeps it from happening.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt_r <= '0;
      long_rd_r <= '0;
    end else if (ex_long_start && !long_busy_s) begin
      lat_cnt_r <= LAT_W'(LONG_LAT);
      long_rd_r <= ex_rd;
    end else if (long_busy_s) begin
      lat_cnt_r <= lat_cnt_r - LAT_W'(1);
      long_rd_r <= long_rd_r;
    end else begin
      lat_cnt_r <= lat_cnt_r;
      long_rd_r <= long_rd_r;
    end
  end

  // Saturating stall counter; clear has priority over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= '0;
    end else if (perf_clr) begin
      stall_cnt_r <= '0;
    end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign forward_a = fwd_a_s;
  assign forward_b = fwd_b_s;
  assign stall     = stall_s;
  assign bubble_ex = stall_s;
  assign flush_if  = ex_branch_taken;
  assign flush_id  = ex_branch_taken;
  assign long_busy = long_busy_s;
  assign long_done = (lat_cnt_r == LAT_W'(1));
  assign long_rd   = long_rd_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic, compared against a time-based behavioural model.
module tb_hazard_ctrl;

  localparam int LAT = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rs, id_uses_rt, id_long;
  logic       ex_reg_write, mem_reg_write, wb_reg_write;
  logic       ex_mem_read, ex_long_start, ex_branch_taken, perf_clr;

  logic [1:0]  forward_a, forward_b;
  logic        stall, bubble_ex, flush_if, flush_id, long_busy, long_done;
  logic [4:0]  long_rd;
  logic [15:0] stall_cnt;

  logic [1:0]  fa3, fb3;
  logic        st3, bx3, fi3, fd3, lb3, ld3;
  logic [4:0]  lr3;
  logic [2:0]  stall_cnt3;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(5), .IGNORE_REG0(1), .LONG_LAT(LAT), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_long(id_long),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write),
    .wb_reg_write(wb_reg_write), .ex_mem_read(ex_mem_read),
    .ex_long_start(ex_long_start), .ex_branch_taken(ex_branch_taken),
    .perf_clr(perf_clr), .forward_a(forward_a), .forward_b(forward_b),
    .stall(stall), .bubble_ex(bubble_ex), .flush_if(flush_if),
    .flush_id(flush_id), .long_busy(long_busy), .long_done(long_done),
    .long_rd(long_rd), .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.REG_W(5), .IGNORE_REG0(1), .LONG_LAT(LAT), .CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_long(id_long),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write),
    .wb_reg_write(wb_reg_write), .ex_mem_read(ex_mem_read),
    .ex_long_start(ex_long_start), .ex_branch_taken(ex_branch_taken),
    .perf_clr(perf_clr), .forward_a(fa3), .forward_b(fb3),
    .stall(st3), .bubble_ex(bx3), .flush_if(fi3), .flush_id(fd3),
    .long_busy(lb3), .long_done(ld3), .long_rd(lr3), .stall_cnt(stall_cnt3)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: the long op is remembered by its issue cycle.
  int cyc     = 0;
  int issue_t = -1000;
  int lrd     = 0;
  int cnt16   = 0;
  int cnt3    = 0;
  bit m_busy, m_stall;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit hit(input int addr, input bit uses, input int rd, input bit we);
    return uses && we && (addr == rd) && (addr != 0);
  endfunction

  function automatic int fwd(input bit e, input bit m, input bit w);
    return e ? 3 : (m ? 1 : (w ? 2 : 0));
  endfunction

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_long = 1'b0; ex_rd = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
    ex_reg_write = 1'b0; mem_reg_write = 1'b0; wb_reg_write = 1'b0;
    ex_mem_read = 1'b0; ex_long_start = 1'b0; ex_branch_taken = 1'b0;
    perf_clr = 1'b0;
  endtask

  task automatic model_reset();
    issue_t = -1000; lrd = 0; cnt16 = 0; cnt3 = 0;
  endtask

  // Let inputs settle, then compare every output against the model.
  task automatic settle_and_check();
    bit ea, eb, ma, mb, wa, wb, la, lb, lu, lo, done;
    #4;
    m_busy = (cyc > issue_t) && (cyc <= issue_t + LAT);
    done   = (cyc == issue_t + LAT);
    ea = hit(id_rs, id_uses_rs, ex_rd, ex_reg_write);
    eb = hit(id_rt, id_uses_rt, ex_rd, ex_reg_write);
    ma = hit(id_rs, id_uses_rs, mem_rd, mem_reg_write);
    mb = hit(id_rt, id_uses_rt, mem_rd, mem_reg_write);
    wa = hit(id_rs, id_uses_rs, wb_rd, wb_reg_write);
    wb = hit(id_rt, id_uses_rt, wb_rd, wb_reg_write);
    la = hit(id_rs, id_uses_rs, lrd, m_busy);
    lb = hit(id_rt, id_uses_rt, lrd, m_busy);
    lu = ex_mem_read && (ea || eb);
    lo = m_busy && (la || lb || id_long);
    m_stall = (lu || lo) && !ex_branch_taken;
    chk("stall",     32'(stall),     32'(m_stall));
    chk("bubble_ex", 32'(bubble_ex), 32'(m_stall));
    chk("forward_a", 32'(forward_a), m_stall ? 0 : fwd(ea, ma, wa));
    chk("forward_b", 32'(forward_b), m_stall ? 0 : fwd(eb, mb, wb));
    chk("flush_if",  32'(flush_if),  32'(ex_branch_taken));
    chk("flush_id",  32'(flush_id),  32'(ex_branch_taken));
    chk("long_busy", 32'(long_busy), 32'(m_busy));
    chk("long_done", 32'(long_done), 32'(done));
    chk("long_rd",   32'(long_rd),   lrd);
    chk("stall_cnt", 32'(stall_cnt), cnt16);
    chk("stall_cnt3", 32'(stall_cnt3), cnt3);
  endtask

  // Commit the clock edge to the model and move to the next cycle.
  task automatic tick();
    if (ex_long_start && !m_busy) begin
      issue_t = cyc;
      lrd     = int'(ex_rd);
    end
    if (perf_clr) begin
      cnt16 = 0; cnt3 = 0;
    end else if (m_stall) begin
      cnt16 = (cnt16 < 65535) ? cnt16 + 1 : 65535;
      cnt3  = (cnt3 < 7) ? cnt3 + 1 : 7;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1'b1; ex_rd = 5'd3; ex_reg_write = 1'b1;
    id_rt = 5'd3; id_uses_rt = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    settle_and_check();                  // reset state, idle inputs
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Forward priority
    id_rs = 5'd5; id_uses_rs = 1'b1; ex_rd = 5'd5; mem_rd = 5'd5; wb_rd = 5'd5;
    ex_reg_write = 1'b1; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
    settle_and_check(); chk("prio_ex", 32'(forward_a), 3); tick();
    ex_reg_write = 1'b0;
    settle_and_check(); chk("prio_mem", 32'(forward_a), 1); tick();
    mem_reg_write = 1'b0;
    settle_and_check(); chk("prio_wb", 32'(forward_a), 2); tick();
    id_rs = 5'd0; ex_rd = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
    ex_reg_write = 1'b1; mem_reg_write = 1'b1;
    settle_and_check(); chk("reg0", 32'(forward_a), 0); tick();

    // Load-use then MEM forward
    idle(); set_load_use();
    settle_and_check(); chk("lu_stall", 32'(stall), 1); chk("lu_fwd", 32'(forward_b), 0); tick();
    idle(); id_rt = 5'd3; id_uses_rt = 1'b1; mem_rd = 5'd3; mem_reg_write = 1'b1;
    settle_and_check(); chk("lu_next", 32'(stall), 0); chk("lu_mem", 32'(forward_b), 1); tick();

    // Long op to r7
    idle(); ex_long_start = 1'b1; ex_rd = 5'd7;
    settle_and_check(); tick();
    for (int k = 1; k <= LAT + 1; k++) begin
      idle(); id_uses_rs = 1'b1;
      id_rs = (k == 3 || k == 4) ? 5'd6 : 5'd7;
      id_long = (k == 4);
      settle_and_check();
      chk("lo_busy", 32'(long_busy), 32'(k <= LAT));
      chk("lo_done", 32'(long_done), 32'(k == LAT));
      chk("lo_stall", 32'(stall), 32'(k <= LAT && k != 3));
      tick();
    end

    // Branch overrides stall; in-flight long op unaffected
    idle(); ex_long_start = 1'b1; ex_rd = 5'd9;
    settle_and_check(); tick();
    for (int k = 1; k <= LAT; k++) begin
      idle();
      if (k == 2) begin
        set_load_use(); ex_branch_taken = 1'b1;
      end else begin
        ex_branch_taken = 1'b0;
      end
      settle_and_check();
      if (k == 2) begin
        chk("br_flush", 32'(flush_if), 1); chk("br_stall", 32'(stall), 0);
      end else begin
        chk("br_noflush", 32'(flush_id), 0);
      end
      chk("br_done", 32'(long_done), 32'(k == LAT));
      tick();
    end

    // Reset in the middle of a long op
    idle(); perf_clr = 1'b0; set_load_use();
    settle_and_check(); tick();          // bump stall_cnt away from zero
    idle(); ex_long_start = 1'b1; ex_rd = 5'd4;
    settle_and_check(); tick();
    idle(); settle_and_check(); tick();
    idle(); settle_and_check(); tick();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(long_busy), 0);
    chk("rst_cnt", 32'(stall_cnt), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < LAT + 2; k++) begin
      idle(); settle_and_check(); chk("rst_nodone", 32'(long_done), 0); tick();
    end

    // Stall counter
    idle(); perf_clr = 1'b1; settle_and_check(); tick();
    for (int k = 0; k < 5; k++) begin
      idle(); set_load_use(); settle_and_check(); tick();
    end
    idle(); settle_and_check(); chk("cnt5", 32'(stall_cnt), 5); tick();
    set_load_use(); perf_clr = 1'b1; settle_and_check(); tick();
    idle(); settle_and_check(); chk("cnt_clr", 32'(stall_cnt), 0); tick();
    for (int k = 0; k < 9; k++) begin
      idle(); set_load_use(); settle_and_check(); tick();
    end
    idle(); settle_and_check();
    chk("cnt9", 32'(stall_cnt), 9); chk("cnt3_sat", 32'(stall_cnt3), 7); tick();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      id_rs = 5'($urandom_range(0, 7));
      id_rt = 5'($urandom_range(0, 7));
      id_uses_rs = 1'($urandom_range(0, 1));
      id_uses_rt = 1'($urandom_range(0, 1));
      id_long = ($urandom_range(0, 5) == 0);
      ex_rd = 5'($urandom_range(0, 7));
      mem_rd = 5'($urandom_range(0, 7));
      wb_rd = 5'($urandom_range(0, 7));
      ex_long_start = ($urandom_range(0, 9) == 0);
      ex_reg_write = ex_long_start ? 1'b0 : 1'($urandom_range(0, 1));
      mem_reg_write = 1'($urandom_range(0, 1));
      wb_reg_write = 1'($urandom_range(0, 1));
      ex_mem_read = ex_reg_write && ($urandom_range(0, 2) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      perf_clr = ($urandom_range(0, 39) == 0);
      settle_and_check();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard, forwarding and scoreboard controller for the in-order 5-stage pipeline, sitting beside the ID stage. It generalises operand forwarding to configurable register-address width and adds four things:
- a scoreboard for one multi-cycle (long-latency) execution unit;
- branch-flush generation;
- load-use and long-op stall generation;
- a saturating stall-cycle performance counter.

## Interface
Parameters:
- REG_W, 5, register-address width (2^REG_W architectural registers)
- IGNORE_REG0, 1, when 1 register 0 never matches (hard-wired zero)
- LONG_LAT, 8, cycles from long-op issue to its write-back pulse; legal range ≥ 2
- CNT_W, 16, stall-counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs, id_rt  in  REG_W each  ID source registers
- id_uses_rs, id_uses_rt  in  1 each  the ID instruction actually reads that source
- id_long  in  1  the ID instruction is itself a long op
- ex_rd, mem_rd, wb_rd  in  REG_W each  destination in EX/MEM/WB
- ex_reg_write, mem_reg_write, wb_reg_write  in  1 each  destination write enables
- ex_mem_read  in  1  EX holds a load
- ex_long_start  in  1  EX issues a long op to destination ex_rd (ex_reg_write is 0 for long ops)
- ex_branch_taken  in  1  EX resolved a taken branch/jump
- perf_clr  in  1  synchronous clear of stall_cnt
- forward_a, forward_b  out  2 each  operand select: 11 EX, 01 MEM, 10 WB, 00 register file
- stall  out  1  freeze PC and IF/ID
- bubble_ex  out  1  insert NOP into ID/EX
- flush_if, flush_id  out  1 each  squash IF/ID and ID/EX contents
- long_busy  out  1  long unit occupied
- long_done  out  1  long result written to register long_rd this cycle
- long_rd  out  REG_W  destination of the in-flight long op
- stall_cnt  out  CNT_W  stall-cycle count

## Operation
- **Match rule.** A source matches a stage when all of these hold: its address equals that stage's rd, the corresponding id_uses_* is 1, that stage's write enable is 1, and the address is not 0 when IGNORE_REG0=1. A long-op match uses long_rd while long_busy=1; it ignores write enables.
- **Forwarding priority per operand.** EX (11), then MEM (01), then WB (10), else 00. While stall=1, both forward outputs are forced to 00.
- **Load-use stall.** Raised when ex_mem_read=1 and either source matches EX. This lasts one cycle; on the next cycle the load is in MEM and forwarding selects 01.
- **Long-op stall.** Raised when long_busy=1 and either of these holds:
  - either source matches long_rd (RAW); this includes the long_done cycle, because the result lands in the register file that cycle;
  - id_long=1 (structural hazard).
- **Combined stall.** stall = (load-use OR long-op) AND NOT ex_branch_taken. bubble_ex = stall.
- **Flush.** ex_branch_taken=1 drives flush_if=flush_id=1 for that cycle only. Flush overrides stall because the ID instruction is discarded. Flush never cancels an in-flight long op, since that op is older.
- **Long scoreboard.** A register cnt (width covering LONG_LAT, reset 0) tracks the long unit.
  - ex_long_start with cnt==0: load cnt=LONG_LAT and latch long_rd=ex_rd.
  - Otherwise, when cnt≠0: decrement cnt.
  - long_busy = (cnt≠0); long_done = (cnt==1).
  - ex_long_start while busy is ignored (protocol violation, prevented by the structural stall).
- **Stall counter.** perf_clr has priority and clears the counter. Otherwise the counter increments on every cycle with stall=1 and saturates at all-ones.

## Timing
- Reset values: cnt=0, long_rd=0, stall_cnt=0, hence long_busy=0 and long_done=0.
- All other outputs are combinational from inputs and registered state. With idle inputs they are 0.
- Reset asserted mid-long-op: the op is dropped with no long_done pulse and long_busy=0 immediately.
- Long op issued at cycle T (ex_long_start sampled at the end of T):
  - long_busy=1 in cycles T+1 … T+LONG_LAT;
  - long_done=1 in cycle T+LONG_LAT only;
  - a dependent ID instruction stalls through T+LONG_LAT and proceeds at T+LONG_LAT+1.
- Back-to-back long ops: the second issues at the earliest in cycle T+LONG_LAT+1.
- Stall and forward outputs depend combinationally on the ID inputs with no register stage. They are valid in the same cycle.
- stall_cnt reflects stalls up to and including the previous cycle.

## Test plan
- Forward priority: rs=5, ex_rd=mem_rd=wb_rd=5, all writes=1 -> forward_a=11. Drop ex_reg_write -> 01. Drop mem_reg_write -> 10. With rs=0 and IGNORE_REG0=1 -> 00.
- Load-use: ex_mem_read=1, ex_rd=3, id_rt=3, id_uses_rt=1 -> stall=bubble_ex=1 and forward_b=00 for one cycle. Next cycle, with mem_rd=3 and mem_reg_write=1 -> stall=0, forward_b=01.
- Long op, LONG_LAT=8: ex_long_start at T with ex_rd=7. long_busy is high T+1..T+8, long_done only at T+8. ID reading r7 stalls through T+8. ID reading r6 does not stall. id_long=1 at T+4 -> stall=1.
- Branch vs stall: load-use condition plus ex_branch_taken=1 in the same cycle -> flush_if=flush_id=1, stall=0. An in-flight long op still produces long_done on schedule.
- Reset mid-op: rst_n low at T+3 of a long op -> long_busy=0 and stall_cnt=0 asynchronously, with no long_done afterwards.
- Counter: 5 stall cycles -> stall_cnt=5. perf_clr together with stall -> 0. With CNT_W=3, 9 stalls -> stall_cnt=7.
